// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM encodings (UART_TX_PARITY_EN adds the parity state)
package uart_pkg;

   localparam int UART_NBITS            = 8;
   localparam int UART_BAUD_DIV_DEFAULT = 10417;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } uart_state_e;
`endif

   function automatic logic even_parity(input logic [UART_NBITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// rtl/uart_tx_baud_tick.sv - bit-period counter, 0..BAUD_DIV-1 with a one-cycle tick on the last count
module baud_tick
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
   parameter int NBITS_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [NBITS_DIV-1:0] LAST = NBITS_DIV'(BAUD_DIV - 1);

   logic [NBITS_DIV-1:0] cnt_q;
   logic [NBITS_DIV-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + NBITS_DIV'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1)
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
   parameter int NBITS_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dataTX,
   output logic       serialTX,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_IDX = 3'(UART_NBITS - 1);

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q,   idx_d;
   logic        serial_q, serial_d;
   logic        done_q,   done_d;
   logic        tick;
`ifdef UART_TX_PARITY_EN
   logic        par_q,    par_d;
`endif

   baud_tick #(
      .BAUD_DIV  (BAUD_DIV),
      .NBITS_DIV (NBITS_DIV)
   ) u_baud_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == ST_IDLE),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d = dataTX;
               idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
               par_d   = even_parity(dataTX);
`endif
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level is registered from the next state so serialTX never glitches.
      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: serial_d = par_d;
`endif
         default:   serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         shift_q  <= 8'h00;
         idx_q    <= 3'd0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         serial_q <= serial_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign serialTX = serial_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - table-driven bench for uart_tx at BAUD_DIV=4 plus a full-rate edge-spacing check
module tb_uart_tx;

   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FC      = NB * BD;
   localparam int SLOW_BD = 10417;

   logic       clk = 1'b0;
   logic       rst, start, start2;
   logic [7:0] data_tx, data_tx2;
   logic       serial, busy, done;
   logic       serial2, busy2, done2;

   always #5 clk = ~clk;

   uart_tx #(.BAUD_DIV(BD), .NBITS_DIV(16)) dut (
      .clk(clk), .rst(rst), .start(start), .dataTX(data_tx),
      .serialTX(serial), .busy(busy), .done(done)
   );

   uart_tx #(.BAUD_DIV(SLOW_BD), .NBITS_DIV(16)) dut_slow (
      .clk(clk), .rst(rst), .start(start2), .dataTX(data_tx2),
      .serialTX(serial2), .busy(busy2), .done(done2)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame10;
      logic       par;
   } vec_t;

   vec_t vecs[8];

   int total = 0;
   int bad   = 0;

   logic       st_plan [0:255];
   logic [7:0] dt_plan [0:255];
   logic       rs_plan [0:255];
   logic       ser_log [0:255];
   logic       busy_log[0:255];
   logic       done_log[0:255];

   task automatic check_bit(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b want=%b", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, got, exp);
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 256; i++) begin
         st_plan[i] = 1'b0;
         dt_plan[i] = 8'h00;
         rs_plan[i] = 1'b1;
      end
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         start   = st_plan[i];
         data_tx = dt_plan[i];
         rst     = rs_plan[i];
         @(posedge clk);
         #1;
         ser_log[i]  = serial;
         busy_log[i] = busy;
         done_log[i] = done;
      end
      start = 1'b0;
      rst   = 1'b1;
   endtask

   function automatic logic [10:0] frame_bits(input vec_t v);
`ifdef UART_TX_PARITY_EN
      return {1'b1, v.par, v.frame10[8:0]};
`else
      return {1'b0, v.frame10};
`endif
   endfunction

   task automatic check_frame(input int off, input vec_t v, input string name);
      logic [10:0] fb;
      logic        got;
      int          busy_n;
      int          done_n;
      fb = frame_bits(v);
      for (int b = 0; b < NB; b++) begin
         got = fb[b];
         for (int k = 0; k < BD; k++)
            if (ser_log[off + b*BD + k] !== fb[b]) got = ser_log[off + b*BD + k];
         check_bit($sformatf("%s bit%0d", name, b), got, fb[b]);
      end
      busy_n = 0;
      done_n = 0;
      for (int c = off; c < off + FC; c++) begin
         if (busy_log[c] === 1'b1) busy_n++;
         if (done_log[c] === 1'b1) done_n++;
      end
      check_int({name, " busy cycles"}, busy_n, FC);
      check_bit({name, " busy end"}, busy_log[off + FC], 1'b0);
      check_int({name, " early done"}, done_n, 0);
      check_bit({name, " done pulse"}, done_log[off + FC], 1'b1);
   endtask

   task automatic wait_level(input logic lvl, input int limit, output int cyc);
      cyc = 0;
      while (serial2 !== lvl && cyc < limit) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int n;
      int cyc;

      vecs[0] = '{8'h55, 10'h2AA, 1'b0};
      vecs[1] = '{8'hA5, 10'h34A, 1'b0};
      vecs[2] = '{8'h3C, 10'h278, 1'b0};
      vecs[3] = '{8'h0F, 10'h21E, 1'b0};
      vecs[4] = '{8'hFF, 10'h3FE, 1'b0};
      vecs[5] = '{8'h07, 10'h20E, 1'b1};
      vecs[6] = '{8'h03, 10'h206, 1'b0};
      vecs[7] = '{8'h80, 10'h300, 1'b1};

      rst = 1'b0; start = 1'b0; start2 = 1'b0; data_tx = 8'h00; data_tx2 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_bit("reset serialTX", serial, 1'b1);
      check_bit("reset busy", busy, 1'b0);
      check_bit("reset done", done, 1'b0);
      check_bit("reset slow serialTX", serial2, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table: data changes every cycle after acceptance and must not leak into the frame.
      for (int i = 0; i < 8; i++) begin
         clear_plan();
         st_plan[0] = 1'b1;
         dt_plan[0] = vecs[i].data;
         for (int j = 1; j < 256; j++) dt_plan[j] = ~vecs[i].data;
         capture(FC + 3);
         check_frame(0, vecs[i], $sformatf("vec%0h", vecs[i].data));
         check_bit($sformatf("vec%0h done width", vecs[i].data), done_log[FC + 1], 1'b0);
      end

      // Back-to-back: second request lands in the done cycle.
      clear_plan();
      st_plan[0] = 1'b1;       dt_plan[0] = 8'hA5;
      st_plan[FC + 1] = 1'b1;  dt_plan[FC + 1] = 8'h3C;
      capture(2*FC + 4);
      check_frame(0, vecs[1], "b2b first");
      check_bit("b2b start bit", ser_log[FC + 1], 1'b0);
      check_frame(FC + 1, vecs[2], "b2b second");

      // Requests while busy are dropped, not queued.
      clear_plan();
      st_plan[0] = 1'b1; dt_plan[0] = 8'h0F;
      for (int j = 1; j < 256; j++) dt_plan[j] = 8'(j * 37);
      st_plan[5] = 1'b1; st_plan[20] = 1'b1; st_plan[FC - 1] = 1'b1;
      capture(FC + 10);
      check_frame(0, vecs[3], "ignore");
      n = 0;
      for (int c = 0; c < FC + 10; c++) if (done_log[c] === 1'b1) n++;
      check_int("ignore done count", n, 1);
      n = 0;
      for (int c = FC + 1; c < FC + 10; c++) if (busy_log[c] !== 1'b0 || ser_log[c] !== 1'b1) n++;
      check_int("ignore no second frame", n, 0);

      // Held start: one frame per acceptance, same latched byte.
      clear_plan();
      for (int j = 0; j <= 2*FC + 1; j++) begin
         st_plan[j] = 1'b1;
         dt_plan[j] = 8'h55;
      end
      capture(2*FC + 4);
      check_frame(0, vecs[0], "held first");
      check_frame(FC + 1, vecs[0], "held second");
      check_bit("held stops", busy_log[2*FC + 2], 1'b0);

      // Reset in cycle 15 of a 0xFF frame.
      clear_plan();
      st_plan[0] = 1'b1; dt_plan[0] = 8'hFF;
      rs_plan[15] = 1'b0;
      capture(FC + 10);
      check_bit("rstmid busy before", busy_log[14], 1'b1);
      check_bit("rstmid serialTX", ser_log[15], 1'b1);
      check_bit("rstmid busy", busy_log[15], 1'b0);
      check_bit("rstmid done", done_log[15], 1'b0);
      n = 0;
      for (int c = 15; c < FC + 10; c++) if (done_log[c] !== 1'b0 || busy_log[c] !== 1'b0) n++;
      check_int("rstmid no done", n, 0);

      // Full-rate divider, byte 0x41: edges at 1, +1, +1, +5 bit periods.
      start2 = 1'b1; data_tx2 = 8'h41;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      wait_level(1'b0, 5, cyc);
      check_int("slow start latency", cyc + 1, 1);
      wait_level(1'b1, 60000, cyc);
      check_int("slow start bit width", cyc, SLOW_BD);
      wait_level(1'b0, 60000, cyc);
      check_int("slow bit0 width", cyc, SLOW_BD);
      wait_level(1'b1, 60000, cyc);
      check_int("slow bits1-5 width", cyc, 5 * SLOW_BD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10417, meaning clock cycles per bit period (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter NBITS_DIV, default 16, meaning width of the bit-period counter.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to send dataTX; level-sampled each clk.
REQ-006 SHALL have port dataTX, input, 8 bits: byte to transmit.
REQ-007 SHALL have port serialTX, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: frame in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-011 In IDLE with start=1, SHALL latch dataTX into a shift register and enter START on the next edge; dataTX changes after acceptance SHALL NOT affect the frame.
REQ-012 serialTX SHALL go low on the first cycle after acceptance; latency start -> start bit = 1 cycle.
REQ-013 Each bit (start, 8 data, parity, stop) SHALL hold serialTX constant for exactly BAUD_DIV cycles, timed by a counter that counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary.
REQ-014 Data bits SHALL be sent LSB first; a 3-bit index SHALL advance 0..7, leaving DATA after bit 7.
REQ-015 STOP SHALL drive serialTX=1 for BAUD_DIV cycles, then return to IDLE.
REQ-016 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-017 done SHALL pulse 1 for exactly the first IDLE cycle after STOP; otherwise 0.
REQ-018 start while busy=1 SHALL be ignored and not queued.
REQ-019 start=1 in the done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit time.
REQ-020 start held high continuously SHALL send the same latched-at-acceptance value repeatedly, one frame per acceptance.
REQ-021 In IDLE, serialTX SHALL be 1 and the bit counter SHALL be held at 0.

Reset
REQ-022 rst=0 at a clk edge SHALL force state IDLE, serialTX=1, busy=0, done=0, counters 0, shift register 0x00.
REQ-023 Reset mid-frame SHALL abort the frame immediately with no done pulse; the line returns high on the following cycle.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined SHALL insert PARITY between DATA and STOP, sending even parity (XOR of the 8 latched bits) for BAUD_DIV cycles; frame = 11 bit periods.
REQ-025 Macro UART_TX_PARITY_EN undefined SHALL remove the PARITY state and logic; frame = 10 bit periods.

Structure
REQ-026 State encodings, the bit count constant (8) and the default BAUD_DIV SHALL live in the shared uart package/include used by the receiver.
REQ-027 The bit-period counter SHALL be a sub-module baud_tick, which produces a one-cycle tick at count BAUD_DIV-1 and is cleared while IDLE.

Verification (BAUD_DIV=4)
REQ-028 Reset, then start=1 for 1 cycle with dataTX=0x55 -> serialTX = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each held 4 cycles; busy=1 for 40 cycles; done pulses on cycle 41.
REQ-029 Send 0xA5 and, in the done cycle, request 0x3C -> second start bit begins on the next cycle; no gap longer than 4 stop cycles.
REQ-030 start pulses and dataTX toggles during a 0x0F frame -> waveform shows only 0x0F, a single done, and no second frame.
REQ-031 rst=0 in cycle 15 of a 0xFF frame -> next cycle serialTX=1, busy=0, done=0, and done never pulses for that frame.
REQ-032 With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-033 BAUD_DIV=10417, 0x41 -> each bit held exactly 10417 cycles; the bench checks edge spacing.
